// File: rtl/rr_bus_arbiter8.sv
// rr_bus_arbiter8 - 8-requester round-robin burst arbiter for the shared
// 32-bit 8:1 result mux. It owns the mux select, hands out a one-hot grant
// for a whole burst (closed by the owner's last flag or by the owner dropping
// its request), and presents a valid/ready handshake toward the consumer.
//
// Optional feature (compile-time macro ARB_BURST_LIMIT_EN):
//   defined   - an 8-bit beat counter force-releases a grant after MAX_BEATS
//               accepted beats when the final beat was not flagged last.
//   undefined - no counter; a grant lasts until last or abandon.
//
// The file also holds rr_bus_arbiter8_chk, the protocol checker that the
// top instantiates; it contains only assertions.

module rr_bus_arbiter8_chk (
    input logic       clk,
    input logic       rst_n,
    input logic [7:0] gnt,
    input logic [7:0] ack,
    input logic [2:0] mux_sel,
    input logic       busy
);

    // At most one requester may hold the bus.
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt));

    // At most one beat acknowledge per cycle.
    a_ack_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(ack));

    // A beat can only be acknowledged to the current owner.
    a_ack_in_gnt: assert property (@(posedge clk) disable iff (!rst_n)
        ((ack & ~gnt) == 8'h00));

    // busy mirrors "some grant is held".
    a_busy_gnt: assert property (@(posedge clk) disable iff (!rst_n)
        (busy == (gnt != 8'h00)));

    // While granted, the select must point at the granted requester.
    a_sel_match: assert property (@(posedge clk) disable iff (!rst_n)
        ((gnt == 8'h00) || (gnt == (8'h01 << mux_sel))));

endmodule

module rr_bus_arbiter8 #(
    parameter int PTR_INIT  = 0,
    parameter int MAX_BEATS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] last,
    input  logic       out_ready,
    output logic [7:0] gnt,
    output logic [2:0] mux_sel,
    output logic       out_valid,
    output logic       out_last,
    output logic [7:0] ack,
    output logic       busy
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    generate
        if ((PTR_INIT < 0) || (PTR_INIT > 7)) begin : g_bad_ptr_init
            $error("rr_bus_arbiter8: PTR_INIT must be in 0..7");
        end
        if ((MAX_BEATS < 1) || (MAX_BEATS > 255)) begin : g_bad_max_beats
            $error("rr_bus_arbiter8: MAX_BEATS must be in 1..255");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [2:0] PTR_RST  = 3'(PTR_INIT);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Binary index to one-hot.
    function automatic logic [7:0] idx_to_onehot(input logic [2:0] idx);
        idx_to_onehot = 8'h01 << idx;
    endfunction

    // Round-robin pick: first set bit scanning p, p+1, ... (mod 8).
    // Returns {found, index}. Scanning from the far end lets the nearest
    // candidate overwrite the result last, so the closest to p wins.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = p + i[2:0];
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0] state_r,  state_nxt_s;
    logic [2:0] ptr_r,    ptr_nxt_s;
    logic [7:0] gnt_r,    gnt_nxt_s;
    logic [2:0] sel_r,    sel_nxt_s;
    logic       busy_r,   busy_nxt_s;

    logic [3:0] pick_s;
    logic       owner_req_s;
    logic       owner_last_s;
    logic       out_valid_s;
    logic       accept_s;
    logic       limit_hit_s;
    logic       release_s;

    // ------------------------------------------------------------------
    // Handshake decode for the current owner
    // ------------------------------------------------------------------

    // Owner's request/last, bus valid and beat acceptance.
    always_comb begin
        owner_req_s  = req[sel_r];
        owner_last_s = last[sel_r];
        out_valid_s  = busy_r & owner_req_s;
        accept_s     = out_valid_s & out_ready;
    end

`ifdef ARB_BURST_LIMIT_EN
    // ------------------------------------------------------------------
    // Burst limit: count accepted beats, force release on the MAX_BEATS-th
    // beat unless that beat already closes the burst.
    // ------------------------------------------------------------------
    localparam logic [7:0] BEAT_LIMIT_IDX = 8'(MAX_BEATS - 1);

    logic [7:0] beat_cnt_r, beat_cnt_nxt_s;

    // The accepted beat is number beat_cnt_r+1; hit when that equals MAX_BEATS.
    always_comb begin
        limit_hit_s = accept_s & ~owner_last_s & (beat_cnt_r == BEAT_LIMIT_IDX);
    end

    // Counter clears on every release, advances on every accepted beat.
    always_comb begin
        beat_cnt_nxt_s = beat_cnt_r;
        if (release_s) begin
            beat_cnt_nxt_s = 8'd0;
        end else if (accept_s) begin
            beat_cnt_nxt_s = beat_cnt_r + 8'd1;
        end else begin
            beat_cnt_nxt_s = beat_cnt_r;
        end
    end

    // Beat counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_r <= 8'd0;
        end else begin
            beat_cnt_r <= beat_cnt_nxt_s;
        end
    end
`else
    // Without the limit feature a grant ends only on last or abandon.
    assign limit_hit_s = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Release and arbitration
    // ------------------------------------------------------------------

    // Release on abandon, on an accepted last beat, or on the beat limit.
    always_comb begin
        release_s = busy_r & (~owner_req_s | (accept_s & owner_last_s) | limit_hit_s);
    end

    // Round-robin winner among the live requests, starting at the pointer.
    always_comb begin
        pick_s = rr_pick(req, ptr_r);
    end

    // Next-state logic for the IDLE/GRANT controller.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        gnt_nxt_s   = gnt_r;
        sel_nxt_s   = sel_r;
        busy_nxt_s  = busy_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_s[3]) begin
                    state_nxt_s = ST_GRANT;
                    gnt_nxt_s   = idx_to_onehot(pick_s[2:0]);
                    sel_nxt_s   = pick_s[2:0];
                    busy_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                    gnt_nxt_s   = 8'h00;
                    sel_nxt_s   = 3'd0;
                    busy_nxt_s  = 1'b0;
                end
            end
            ST_GRANT: begin
                if (release_s) begin
                    // Always return to IDLE: guarantees an idle cycle
                    // between grants and rotates priority past the owner.
                    state_nxt_s = ST_IDLE;
                    ptr_nxt_s   = sel_r + 3'd1;
                    gnt_nxt_s   = 8'h00;
                    sel_nxt_s   = 3'd0;
                    busy_nxt_s  = 1'b0;
                end else begin
                    // Stalled or mid-burst: hold everything.
                    state_nxt_s = ST_GRANT;
                    ptr_nxt_s   = ptr_r;
                    gnt_nxt_s   = gnt_r;
                    sel_nxt_s   = sel_r;
                    busy_nxt_s  = busy_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                ptr_nxt_s   = PTR_RST;
                gnt_nxt_s   = 8'h00;
                sel_nxt_s   = 3'd0;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // Controller registers; reset drops any grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ptr_r   <= PTR_RST;
            gnt_r   <= 8'h00;
            sel_r   <= 3'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            gnt_r   <= gnt_nxt_s;
            sel_r   <= sel_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign gnt       = gnt_r;
    assign mux_sel   = sel_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_s;
    assign out_last  = out_valid_s & owner_last_s;
    assign ack       = accept_s ? idx_to_onehot(sel_r) : 8'h00;

    // ------------------------------------------------------------------
    // Protocol checker
    // ------------------------------------------------------------------
    rr_bus_arbiter8_chk u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .gnt     (gnt_r),
        .ack     (ack),
        .mux_sel (sel_r),
        .busy    (busy_r)
    );

endmodule

// File: tb/tb_rr_bus_arbiter8.sv
// Testbench for rr_bus_arbiter8. Directed stimulus pushes the expected grant
// order and beat acknowledges into queues; a monitor pops and compares them
// whenever a new grant or an ack appears. Cycle-exact timing points are
// checked directly by the stimulus process.

module tb_rr_bus_arbiter8;

`ifdef ARB_BURST_LIMIT_EN
    localparam int MAXB = 4;
`else
    localparam int MAXB = 16;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] last;
    logic       out_ready;
    logic [7:0] gnt;
    logic [2:0] mux_sel;
    logic       out_valid;
    logic       out_last;
    logic [7:0] ack;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    int         exp_gnt[$];   // expected owner index of each new grant
    logic [3:0] exp_ack[$];   // expected {last, owner} of each ack

    rr_bus_arbiter8 #(.PTR_INIT(0), .MAX_BEATS(MAXB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .last      (last),
        .out_ready (out_ready),
        .gnt       (gnt),
        .mux_sel   (mux_sel),
        .out_valid (out_valid),
        .out_last  (out_last),
        .ack       (ack),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next active edge, where inputs are driven.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ack(input int owner, input logic lst, input int n);
        for (int i = 0; i < n; i++) begin
            exp_ack.push_back({lst, 3'(owner)});
        end
    endtask

    // Monitor: compare every new grant and every ack against the queues.
    initial begin : monitor
        logic [7:0] prev_gnt;
        int         eg;
        logic [3:0] ea;
        logic [2:0] eo;
        prev_gnt = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_gnt = 8'h00;
            end else begin
                if ((gnt != 8'h00) && (prev_gnt == 8'h00)) begin
                    if (exp_gnt.size() == 0) begin
                        chk("unexpected_grant", {24'h0, gnt}, 32'h0);
                    end else begin
                        eg = exp_gnt.pop_front();
                        eo = 3'(eg);
                        chk("grant_sel", {29'h0, mux_sel}, {29'h0, eo});
                        chk("grant_onehot", {24'h0, gnt}, {24'h0, 8'h01 << eo});
                    end
                end
                if (ack != 8'h00) begin
                    if (exp_ack.size() == 0) begin
                        chk("unexpected_ack", {24'h0, ack}, 32'h0);
                    end else begin
                        ea = exp_ack.pop_front();
                        eo = ea[2:0];
                        chk("ack_owner", {24'h0, ack}, {24'h0, 8'h01 << eo});
                        chk("ack_last", {31'h0, out_last}, {31'h0, ea[3]});
                    end
                end
                prev_gnt = gnt;
            end
        end
    end

    // Stimulus.
    initial begin : stim
        int b1;
        int b2;
        rst_n     = 1'b0;
        req       = 8'h00;
        last      = 8'h00;
        out_ready = 1'b0;

        // ---- 1: reset state, then idle with no requests ----
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt", {24'h0, gnt}, 32'h0);
        chk("rst_sel", {29'h0, mux_sel}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_ack", {24'h0, ack}, 32'h0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_gnt", {24'h0, gnt}, 32'h0);
            chk("idle_busy", {31'h0, busy}, 32'h0);
            chk("idle_valid", {31'h0, out_valid}, 32'h0);
            cyc();
        end

        // ---- 2: req 0 and 7, single-beat bursts, pointer wrap ----
        exp_gnt.push_back(0); exp_gnt.push_back(7); exp_gnt.push_back(0);
        push_ack(0, 1'b1, 1); push_ack(7, 1'b1, 1); push_ack(0, 1'b1, 1);
        req = 8'h81; last = 8'hFF; out_ready = 1'b1;
        @(negedge clk); chk("t2_latency", {24'h0, gnt}, 32'h0);
        cyc(); @(negedge clk);
        chk("t2_gnt0", {24'h0, gnt}, 32'h01);
        chk("t2_ack0", {24'h0, ack}, 32'h01);
        cyc(); @(negedge clk);
        chk("t2_gap1", {24'h0, gnt}, 32'h0);
        chk("t2_gap1_busy", {31'h0, busy}, 32'h0);
        cyc(); @(negedge clk);
        chk("t2_gnt7", {24'h0, gnt}, 32'h80);
        chk("t2_sel7", {29'h0, mux_sel}, 32'h7);
        cyc(); @(negedge clk);
        chk("t2_gap2", {24'h0, gnt}, 32'h0);
        cyc(); @(negedge clk);
        chk("t2_wrap", {24'h0, gnt}, 32'h01);
        cyc(); req = 8'h00;
        @(negedge clk); chk("t2_end", {24'h0, gnt}, 32'h0);

        // ---- 3: 4-beat burst from 3 with out_ready toggling ----
        exp_gnt.push_back(3);
        push_ack(3, 1'b0, 3); push_ack(3, 1'b1, 1);
        cyc(); req = 8'h08; last = 8'h00; out_ready = 1'b0;
        @(negedge clk); chk("t3_arb", {24'h0, gnt}, 32'h0);
        for (int k = 0; k < 7; k++) begin
            cyc();
            out_ready = (k % 2 == 0);
            last      = (k == 6) ? 8'h08 : 8'h00;
            @(negedge clk);
            chk("t3_busy", {31'h0, busy}, 32'h1);
            chk("t3_sel", {29'h0, mux_sel}, 32'h3);
            chk("t3_ack", {24'h0, ack}, (k % 2 == 0) ? 32'h08 : 32'h00);
        end
        cyc(); req = 8'h00; last = 8'h00; out_ready = 1'b1;
        @(negedge clk);
        chk("t3_busy_drop", {31'h0, busy}, 32'h0);

        // ---- 4: owner 2 abandons after 2 beats, pending 4 wins next ----
        exp_gnt.push_back(2); exp_gnt.push_back(4);
        push_ack(2, 1'b0, 2); push_ack(4, 1'b1, 1);
        cyc(); req = 8'h04;
        @(negedge clk); chk("t4_arb", {24'h0, gnt}, 32'h0);
        cyc(); @(negedge clk);
        chk("t4_gnt2", {24'h0, gnt}, 32'h04);
        chk("t4_ack_a", {24'h0, ack}, 32'h04);
        cyc(); req = 8'h14;
        @(negedge clk); chk("t4_ack_b", {24'h0, ack}, 32'h04);
        cyc(); req = 8'h10; last = 8'h10;
        @(negedge clk);
        chk("t4_abandon_ack", {24'h0, ack}, 32'h0);
        chk("t4_abandon_valid", {31'h0, out_valid}, 32'h0);
        chk("t4_abandon_busy", {31'h0, busy}, 32'h1);
        cyc(); @(negedge clk);
        chk("t4_gap", {24'h0, gnt}, 32'h0);
        cyc(); @(negedge clk);
        chk("t4_gnt4", {24'h0, gnt}, 32'h10);
        chk("t4_last4", {31'h0, out_last}, 32'h1);
        cyc(); req = 8'h00;
        @(negedge clk); chk("t4_end", {24'h0, gnt}, 32'h0);

        // ---- 5: reset in the middle of a stalled grant to 6 ----
        exp_gnt.push_back(6); exp_gnt.push_back(0);
        push_ack(0, 1'b1, 1);
        cyc(); req = 8'h40; last = 8'h00; out_ready = 1'b0;
        @(negedge clk); chk("t5_arb", {24'h0, gnt}, 32'h0);
        cyc(); @(negedge clk);
        chk("t5_gnt6", {24'h0, gnt}, 32'h40);
        #2;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        chk("t5_async_gnt", {24'h0, gnt}, 32'h0);
        chk("t5_async_busy", {31'h0, busy}, 32'h0);
        chk("t5_async_ack", {24'h0, ack}, 32'h0);
        cyc(); @(negedge clk);
        chk("t5_hold_gnt", {24'h0, gnt}, 32'h0);
        cyc(); rst_n = 1'b1; req = 8'hFF; last = 8'hFF;
        @(negedge clk); chk("t5_arb2", {24'h0, gnt}, 32'h0);
        cyc(); @(negedge clk);
        chk("t5_gnt0", {24'h0, gnt}, 32'h01);
        cyc(); req = 8'h00;
        @(negedge clk); chk("t5_end", {24'h0, gnt}, 32'h0);

        // ---- 6: 10-beat burst from 1 with 2 pending ----
`ifdef ARB_BURST_LIMIT_EN
        exp_gnt.push_back(1); exp_gnt.push_back(2);
        exp_gnt.push_back(1); exp_gnt.push_back(1);
        push_ack(1, 1'b0, 4); push_ack(2, 1'b1, 1);
        push_ack(1, 1'b0, 4); push_ack(1, 1'b0, 1); push_ack(1, 1'b1, 1);
`else
        exp_gnt.push_back(1); exp_gnt.push_back(2);
        push_ack(1, 1'b0, 9); push_ack(1, 1'b1, 1); push_ack(2, 1'b1, 1);
`endif
        b1 = 0;
        b2 = 0;
        for (int k = 0; (k < 80) && !((b1 == 10) && (b2 == 1) && !busy); k++) begin
            cyc();
            req       = {5'b0, (b2 < 1), (b1 < 10), 1'b0};
            last      = {5'b0, 1'b1, (b1 == 9), 1'b0};
            out_ready = 1'b1;
            @(negedge clk);
            if (ack[1]) b1++;
            if (ack[2]) b2++;
        end
        chk("t6_beats1", b1, 32'd10);
        chk("t6_beats2", b2, 32'd1);
        cyc(); req = 8'h00; last = 8'h00;
        @(negedge clk);
        chk("t6_idle", {31'h0, busy}, 32'h0);

        // ---- wrap-up ----
        cyc(); @(negedge clk);
        chk("gnt_queue_drained", exp_gnt.size(), 32'd0);
        chk("ack_queue_drained", exp_ack.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
